// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern engine: mode encodings and the
// triangle-wave helper used to turn a phase into a PWM duty.
package led_pattern_pkg;

    localparam logic [1:0] MODE_BLINK   = 2'b00;
    localparam logic [1:0] MODE_BREATHE = 2'b01;
    localparam logic [1:0] MODE_CHASE   = 2'b10;
    localparam logic [1:0] MODE_WAVE    = 2'b11;

    // Triangle of a (bits+1)-wide phase: the low half ramps up, the high half
    // mirrors it back down. Supports amplitudes up to 16 bits.
    function automatic logic [15:0] tri_val(input logic [16:0] p, input int unsigned bits);
        logic [16:0] mask;
        mask = (17'd1 << bits) - 17'd1;
        if (((p >> bits) & 17'd1) != 17'd0)
            return 16'(~p & mask);
        else
            return 16'(p & mask);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-bit key synchroniser and debouncer. A new key value becomes the
// accepted mode only after it has been stable for DEBOUNCE_CYC cycles;
// mode_chg flags the clock on which that acceptance takes effect.
module key_debounce
    import led_pattern_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 65536
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] key,
    output logic [1:0] mode,
    output logic       mode_chg
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       key_m;
    logic [1:0]       key_s;
    logic [1:0]       key_prev;
    logic [CNT_W-1:0] cnt;

    // Synchronise the raw keys and keep one extra stage to spot changes.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, giving a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_m    <= 2'b00;
            key_s    <= 2'b00;
            key_prev <= 2'b00;
        end else begin
            key_m    <= key;
            key_s    <= key_m;
            key_prev <= key_s;
        end
    end

    // Accept the synchronised key once it has held steady long enough.
    assign mode_chg = (key_s == key_prev) && (key_s != mode) && (cnt == CNT_MAX);

    // Stability counter and accepted-mode register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            mode <= MODE_BLINK;
        end else if (mode_chg) begin
            mode <= key_s;
            cnt  <= '0;
        end else if ((key_s != key_prev) || (key_s == mode)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// Multi-channel LED driver: debounced keys select blink, breathe, chase or
// phase-offset wave. A shared PWM counter is compared against per-channel
// duties taken from a triangle of the phase accumulator.
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int N_LED        = 6,
    parameter int PWM_BITS     = 8,
    parameter int TICK_DIV     = 1024,
    parameter int DEBOUNCE_CYC = 65536,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       key,
    output logic [N_LED-1:0] led,
    output logic [1:0]       mode
);

    localparam int              PH_W    = PWM_BITS + 1;
    localparam int              TICK_W  = $clog2(TICK_DIV);
    localparam int              OFS     = (1 << PH_W) / N_LED;
    localparam logic [N_LED-1:0] LED_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

    logic                mode_chg;
    logic [TICK_W-1:0]   presc;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PH_W-1:0]     phase;
    logic [3:0]          step;
    logic [4:0]          chase_idx;
    logic [PWM_BITS-1:0] breathe_duty;
    logic [PWM_BITS-1:0] wave_duty [N_LED];
    logic [N_LED-1:0]    on;

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .key     (key),
        .mode    (mode),
        .mode_chg(mode_chg)
    );

    assign tick         = (presc == TICK_W'(TICK_DIV - 1));
    assign chase_idx    = {1'b0, step} % 5'(N_LED);
    assign breathe_duty = PWM_BITS'(tri_val(17'(phase), PWM_BITS));

    // Free-running PWM counter shared by every channel; mode changes leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end

    // Timebase: prescaler -> phase -> step, restarted whenever the mode changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            phase <= '0;
            step  <= '0;
        end else if (mode_chg) begin
            presc <= '0;
            phase <= '0;
            step  <= '0;
        end else if (tick) begin
            presc <= '0;
            phase <= phase + PH_W'(1);
            if (phase == '1) step <= step + 4'd1;
        end else begin
            presc <= presc + TICK_W'(1);
        end
    end

    // Per-channel wave duty: each channel sees the phase shifted by i*OFS.
    always_comb begin
        for (int i = 0; i < N_LED; i++) begin
            wave_duty[i] = PWM_BITS'(tri_val(17'(phase + PH_W'(i * OFS)), PWM_BITS));
        end
    end

    // Pattern mux: decide which channels are lit this clock.
    // NOTE: 'on' gets a full default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        on = '0;
        for (int i = 0; i < N_LED; i++) begin
            case (mode)
                MODE_BLINK:   on[i] = step[0];
                MODE_BREATHE: on[i] = (pwm_cnt < breathe_duty);
                MODE_CHASE:   on[i] = (chase_idx == 5'(i));
                default:      on[i] = (pwm_cnt < wave_duty[i]);
            endcase
        end
    end

    // Registered pin drive with board polarity applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led <= LED_OFF;
        else        led <= on ^ LED_OFF;
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine. A reference model driven by
// elapsed clocks since the last timebase restart predicts led and mode after
// every edge; a monitor compares them against the DUT on the falling edge.
module tb_led_pattern_engine;

    localparam int N_LED        = 6;
    localparam int PWM_BITS     = 3;
    localparam int TICK_DIV     = 4;
    localparam int DEBOUNCE_CYC = 8;
    localparam int PWM_MOD      = 1 << PWM_BITS;
    localparam int PH_MOD       = 1 << (PWM_BITS + 1);
    localparam int HIST_LEN     = DEBOUNCE_CYC + 3;

    typedef struct {
        logic [N_LED-1:0] led;
        logic [1:0]       mode;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [1:0]       key;
    logic [N_LED-1:0] led;
    logic [1:0]       mode;

    int checks = 0;
    int errors = 0;

    exp_t       exp_q[$];
    logic [1:0] hist[$];
    int         m_t;
    int         m_pwm;
    logic [1:0] m_mode;

    led_pattern_engine #(
        .N_LED       (N_LED),
        .PWM_BITS    (PWM_BITS),
        .TICK_DIV    (TICK_DIV),
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .key  (key),
        .led  (led),
        .mode (mode)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int tri_ref(input int p);
        return (p < PWM_MOD) ? p : (PH_MOD - 1 - p);
    endfunction

    // Pin state predicted from the pattern rules, given clocks since restart.
    function automatic logic [N_LED-1:0] model_led(input int t, input int pwm, input logic [1:0] md);
        int phase;
        int step;
        logic [N_LED-1:0] lit;
        phase = (t / TICK_DIV) % PH_MOD;
        step  = (t / (TICK_DIV * PH_MOD)) % 16;
        lit   = '0;
        for (int i = 0; i < N_LED; i++) begin
            case (md)
                2'b00:   lit[i] = (step % 2) == 1;
                2'b01:   lit[i] = pwm < tri_ref(phase);
                2'b10:   lit[i] = (i == step % N_LED);
                default: lit[i] = pwm < tri_ref((phase + i * (PH_MOD / N_LED)) % PH_MOD);
            endcase
        end
        return ~lit;
    endfunction

    // Reference model: one step per rising edge. A key value is accepted when
    // it was sampled on DEBOUNCE_CYC+1 consecutive edges, ending two edges ago.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_q.delete();
                hist.delete();
                for (int i = 0; i < HIST_LEN; i++) hist.push_back(2'b00);
                m_t    = 0;
                m_pwm  = 0;
                m_mode = 2'b00;
            end else begin
                exp_t e;
                logic upd;
                e.led = model_led(m_t, m_pwm, m_mode);
                hist.push_back(key);
                void'(hist.pop_front());
                upd = (hist[0] != m_mode);
                for (int i = 1; i <= DEBOUNCE_CYC; i++)
                    if (hist[i] != hist[0]) upd = 1'b0;
                if (upd) begin
                    m_mode = hist[0];
                    m_t    = 0;
                end else begin
                    m_t = m_t + 1;
                end
                m_pwm  = (m_pwm + 1) % PWM_MOD;
                e.mode = m_mode;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: compare the DUT pins against the oldest prediction.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("led", 32'(led), 32'(e.led));
                check("mode", 32'(mode), 32'(e.mode));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int lat;
        int tries;
        logic found;

        rst_n = 1'b0;
        key   = 2'b00;

        // 1. reset and blink
        clocks(5);
        check("reset_led", 32'(led), 32'h3f);
        check("reset_mode", 32'(mode), 32'h0);
        rst_n = 1'b1;
        clocks(100);
        @(posedge clk);
        #2;
        check("blink_on_before_reset", 32'(led), 32'h00);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_led", 32'(led), 32'h3f);
        check("async_reset_mode", 32'(mode), 32'h0);
        clocks(3);
        rst_n = 1'b1;
        clocks(150);

        // 2. debounce: short glitch, then a held request
        key = 2'b01;
        clocks(5);
        key = 2'b00;
        clocks(20);
        check("glitch_mode", 32'(mode), 32'h0);
        key = 2'b01;
        @(posedge clk);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (mode == 2'b01) begin
                lat = i;
                break;
            end
        end
        check("debounce_latency", 32'(lat), 32'd10);
        check("chg_phase_clear", 32'(dut.phase), 32'h0);
        check("chg_step_clear", 32'(dut.step), 32'h0);

        // 3. breathe
        clocks(300);

        // 4. chase, long enough to cross the step 15->0 wrap
        key = 2'b10;
        clocks(1100);

        // 5. wave
        key = 2'b11;
        clocks(400);

        // 6. wave -> blink landing on a tick
        tries = 0;
        while ((m_t % TICK_DIV) != 1 && tries < 20) begin
            clocks(1);
            tries++;
        end
        key   = 2'b00;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dut.mode_chg) begin
                found = 1'b1;
                break;
            end
        end
        check("chg_seen", 32'(found), 32'h1);
        check("chg_on_tick", 32'(dut.tick), 32'h1);
        @(negedge clk);
        check("tick_chg_phase", 32'(dut.phase), 32'h0);
        check("tick_chg_step", 32'(dut.step), 32'h0);
        check("tick_chg_mode", 32'(mode), 32'h0);
        @(negedge clk);
        check("tick_chg_led", 32'(led), 32'h3f);

        // 7. random key activity, including near-threshold hold lengths
        for (int s = 0; s < 40; s++) begin
            key = 2'($urandom_range(0, 3));
            clocks($urandom_range(1, 24));
        end
        clocks(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
Parametrised multi-channel LED driver that generalises the two-key blink/breathe board demo into N_LED channels with four selectable patterns.
- Two board keys are synchronised and debounced, then select the pattern: blink, breathe, chase or phase-offset breathing wave.
- Brightness uses a shared PWM counter, with a per-channel duty derived from a triangle-wave phase accumulator.
- Sits directly between board pins (key, led) and the clock.

Parameters:
- N_LED, 6: number of LED channels (2..16).
- PWM_BITS, 8: PWM resolution. Also the triangle amplitude width.
- TICK_DIV, 1024: clocks per timebase tick (>=2).
- DEBOUNCE_CYC, 65536: stable cycles required before a key change is accepted (>=2).
- ACTIVE_LOW, 1: 1 means LED pins are driven low when the LED is on.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- key  in  2  raw asynchronous board keys. Used as the mode request.
- led  out  N_LED  LED pins, registered; polarity set by ACTIVE_LOW.
- mode  out  2  currently accepted mode (debug), registered.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - mode=00; all counters, phase and step = 0.
  - led = all LEDs off: all 1s if ACTIVE_LOW, else all 0s.
  - Release is synchronous to clk; the first tick occurs TICK_DIV clocks after release.
- Key synchroniser: 2-flop synchroniser per bit, giving key_s.
- Debounce:
  - The counter resets to 0 whenever key_s changes or key_s==mode.
  - Otherwise it increments each clock.
  - When the counter reaches DEBOUNCE_CYC-1: mode<=key_s and counter<=0.
  - A steady key change is reflected on mode exactly 2+DEBOUNCE_CYC clocks after the first clock edge that samples it.
  - A glitch shorter than DEBOUNCE_CYC never changes mode.
- Mode change: on the clock that mode updates, the prescaler, phase and step all clear to 0. pwm_cnt is not cleared.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for one clock when the count is TICK_DIV-1.
- PWM counter: pwm_cnt, PWM_BITS wide, free-running +1 every clock, wraps from 2^PWM_BITS-1 to 0.
- Phase accumulator:
  - phase is PWM_BITS+1 bits and increments on tick.
  - On wrap to 0, step (4 bits, mod-16 wrap) increments.
- Triangle function: tri(p) = p[MSB] ? ~p[PWM_BITS-1:0] : p[PWM_BITS-1:0].
- Per-channel on condition on_i, by mode:
  - 00 BLINK: on_i = step[0], all channels together.
  - 01 BREATHE: on_i = (pwm_cnt < tri(phase)).
  - 10 CHASE: on_i = (i == step mod N_LED). One-hot; wraps from N_LED-1 to 0.
  - 11 WAVE: on_i = (pwm_cnt < tri(phase + i*OFS)).
    - OFS = 2^(PWM_BITS+1)/N_LED, integer division.
    - Addition is modulo 2^(PWM_BITS+1).
- Duty boundaries: duty 0 gives an LED that is always off; the maximum duty 2^PWM_BITS-1 is on for all but one pwm_cnt value.
- Output latency: led = on XOR {N_LED{ACTIVE_LOW}}, registered, 1 clock after on_i is computed.
- Simultaneous events:
  - If tick and a mode update coincide, the mode update wins: phase is cleared, not incremented.
  - If the phase wrap and step update coincide with a mode update, step is also cleared.

Decomposition:
- Package led_pattern_pkg:
  - Mode localparams MODE_BLINK=2'b00, MODE_BREATHE=2'b01, MODE_CHASE=2'b10, MODE_WAVE=2'b11.
  - Function tri().
- Sub-module key_debounce (2-bit sync + debounce, parameter DEBOUNCE_CYC). Outputs the accepted mode plus a one-clock mode_chg pulse.
- The rest (timebase, PWM, pattern mux) lives in led_pattern_engine.

Test Plan:
Common parameters: N_LED=6, PWM_BITS=3, TICK_DIV=4, DEBOUNCE_CYC=8, ACTIVE_LOW=1, 20 ns clock.
1. Reset and blink:
   - Stimulus: hold rst_n=0 for 5 clk, then release with key=00.
   - During reset: led=6'b111111, mode=00.
   - After release: led toggles between 111111 and 000000 every 64 clocks (16 ticks x 4).
   - Assert rst_n=0 mid-pattern: led returns to 111111 immediately, without waiting for a clock edge.
2. Debounce:
   - Stimulus: key=01 pulse of 5 clocks.
   - Response: mode stays 00.
   - Stimulus: key=01 held.
   - Response: mode=01 exactly 10 clocks after the first sampling edge; phase and step are 0 on the next clock.
3. Breathe:
   - Stimulus: mode=01.
   - Response: per 8-clock PWM frame, the count of active-low 0s on led[0] follows the triangle sequence 0,1,...,7,7,6,...,0 as phase advances.
   - All 6 LEDs are identical at all times.
4. Chase:
   - Stimulus: mode=10.
   - Response: led = ~(6'b000001<<(step mod 6)).
   - The one-hot walks every 64 clocks and wraps from bit 5 to bit 0. Check across the step 15->0 wrap: pattern bit 3 goes to bit 0.
5. Wave:
   - Stimulus: mode=11.
   - Response: OFS=16/6=2, so channel i duty = tri(phase+2i).
   - At phase=0, the duties are 0,2,4,6,7,5.
   - Bench compares led against a reference model every clock.
6. Mode change at tick:
   - Stimulus: time the mode 11->00 update onto a clock where tick=1.
   - Response: phase=0 and step=0 afterwards, with no increment applied.
   - led shows the blink pattern, with step[0]=0 giving 111111, one clock later.
